// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- definitions shared by the stack CPU and its instruction fetch unit.
//
// Contents:
//   OPCODE_W / OPERAND_W   instruction field widths (opcode sits in the MSBs)
//   OP_*                   opcode constants the fetch unit and CPU agree on
//   fetch_state_t, ST_*    instruction fetch FSM encoding
//   opcode_of()            extracts the opcode field from an instruction word
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 11;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OP_PUSH_I = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD    = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_CALL   = 5'd20;
  localparam logic [OPCODE_W-1:0] OP_RET    = 5'd21;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 5'd31;

  // Plain 2-bit encoding so the state value is stable across tools.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_FETCH   = 2'd1;
  localparam fetch_state_t ST_PRESENT = 2'd2;
  localparam fetch_state_t ST_HALTED  = 2'd3;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem -- single-port program memory, synchronous read and write.
//
// Ports:
//   clk    in   system clock, rising edge
//   we     in   write enable: mem[addr] <= wdata
//   re     in   read enable:  rdata <= mem[addr]; rdata holds when re=0
//   addr   in   AWIDTH-bit shared read/write address
//   wdata  in   write data
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module instr_mem #(
  parameter int WIDTH_DATA = 16,
  parameter int AWIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [WIDTH_DATA-1:0] wdata,
  output logic [WIDTH_DATA-1:0] rdata
);

  logic [WIDTH_DATA-1:0] mem [2**AWIDTH];

  // NOTE: no reset on the array or rdata -- a reset loop over storage would
  // stop this mapping onto RAM, and the program is loaded explicitly anyway.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- program memory + program counter feeding the stack CPU with
// 16-bit instructions over a valid/ready handshake. Stops on OP_HALT and
// accepts CALL/RET redirects from the CPU.
//
// Optional feature macro: IFETCH_PREFETCH_EN
//   defined   -> 1-entry prefetch, one instruction per cycle with ready high
//   undefined -> one instruction every 2 cycles
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high reset
//   run             in   pulse: start fetching at address 0 (IDLE/HALTED only)
//   load_we         in   program write enable (honoured in IDLE/HALTED only)
//   load_addr       in   program write address
//   load_data       in   program write data
//   redirect_valid  in   fetch from redirect_addr next (FETCH/PRESENT only)
//   redirect_addr   in   redirect target
//   instr           out  presented instruction (0 when not valid)
//   instr_valid     out  instr is valid
//   instr_ready     in   CPU accepts instr
//   pc              out  address of the presented instruction
//   halted          out  a HALT was consumed; fetching stopped
// ---------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int WIDTH_DATA = 16,
  parameter int AWIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  load_we,
  input  logic [AWIDTH-1:0]     load_addr,
  input  logic [WIDTH_DATA-1:0] load_data,
  input  logic                  redirect_valid,
  input  logic [AWIDTH-1:0]     redirect_addr,
  output logic [WIDTH_DATA-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [AWIDTH-1:0]     pc,
  output logic                  halted
);

  fetch_state_t          state;
  logic [AWIDTH-1:0]     fetch_addr;
  logic [WIDTH_DATA-1:0] mem_rdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [AWIDTH-1:0]     mem_addr;
  logic                  pf_read;
  logic                  handshake;
  logic                  redirect;
  logic                  is_halt;

  // Loads are only legal while the fetch engine is parked, so the single
  // port never has a read and a write competing.
  assign mem_we    = load_we && (state == ST_IDLE || state == ST_HALTED);
  assign mem_addr  = mem_we ? load_addr : fetch_addr;
  assign mem_re    = (state == ST_FETCH) || pf_read;
  assign handshake = instr_valid && instr_ready;
  assign redirect  = redirect_valid && (state == ST_FETCH || state == ST_PRESENT);
  assign is_halt   = (instr[WIDTH_DATA-1 -: OPCODE_W] == OP_HALT);

  instr_mem #(
    .WIDTH_DATA (WIDTH_DATA),
    .AWIDTH     (AWIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (load_data),
    .rdata (mem_rdata)
  );

`ifdef IFETCH_PREFETCH_EN
  // Presentation alternates between two sources: the memory output register
  // (right after a FETCH or a handshake) and instr_q, which takes a copy of
  // the presented word when a prefetch read reuses the memory output.
  // pf_valid=1 means mem_rdata already holds the next word.
  logic                  pf_valid;
  logic [WIDTH_DATA-1:0] instr_q;

  assign pf_read = (state == ST_PRESENT) && !pf_valid;
  assign instr   = !instr_valid ? '0 : (pf_valid ? instr_q : mem_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_valid <= 1'b0;
      instr_q  <= '0;
    end else if (state != ST_PRESENT || redirect || handshake) begin
      pf_valid <= 1'b0;
    end else if (pf_read) begin
      pf_valid <= 1'b1;
      instr_q  <= mem_rdata;
    end
  end
`else
  // The memory output register only reloads in FETCH, so it is stable for
  // the whole PRESENT phase and can drive instr directly.
  assign pf_read = 1'b0;
  assign instr   = instr_valid ? mem_rdata : '0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_addr  <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state      <= ST_FETCH;
            fetch_addr <= '0;
          end
        end
        ST_HALTED: begin
          if (run) begin
            state      <= ST_FETCH;
            fetch_addr <= '0;
            halted     <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (redirect) begin
            // The read issued this cycle is discarded; re-read at the target.
            fetch_addr <= redirect_addr;
          end else begin
            state       <= ST_PRESENT;
            instr_valid <= 1'b1;
            pc          <= fetch_addr;
            fetch_addr  <= fetch_addr + 1'b1;
          end
        end
        ST_PRESENT: begin
          if (redirect) begin
            // Wins over a same-cycle handshake; an unaccepted word is dropped.
            state       <= ST_FETCH;
            instr_valid <= 1'b0;
            fetch_addr  <= redirect_addr;
          end else if (handshake && is_halt) begin
            state       <= ST_HALTED;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
`ifdef IFETCH_PREFETCH_EN
            if (pf_read) fetch_addr <= fetch_addr + 1'b1;
            // The next word is in mem_rdata: either prefetched earlier
            // (address fetch_addr-1) or being read at this edge (fetch_addr).
            if (handshake) pc <= pf_valid ? fetch_addr - 1'b1 : fetch_addr;
`else
            if (handshake) begin
              state       <= ST_FETCH;
              instr_valid <= 1'b0;
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction supplier for the stack CPU. It holds a 2^AWIDTH-word program memory and a program counter, and presents 16-bit instructions (5-bit opcode, 11-bit operand) to the CPU over a valid/ready handshake. It accepts control-flow redirects (CALL/RET targets) from the CPU and stops on a HALT opcode. It replaces the bench-driven instruction input in front of the cpu module.

Parameters:
WIDTH_DATA, 16, instruction width (opcode 5 MSBs, operand remaining bits)
AWIDTH, 5, program address width; memory depth 2^AWIDTH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  one-cycle pulse; starts fetching at address 0 from IDLE or HALTED
load_we  in  1  program memory write enable
load_addr  in  AWIDTH  program memory write address
load_data  in  WIDTH_DATA  program memory write data
redirect_valid  in  1  CPU requests a fetch from redirect_addr
redirect_addr  in  AWIDTH  redirect target
instr  out  WIDTH_DATA  presented instruction
instr_valid  out  1  instr is valid
instr_ready  in  1  CPU accepts instr
pc  out  AWIDTH  address of the presented instr
halted  out  1  HALT consumed; fetching stopped

Behaviour:
- Reset (synchronous, active-high): state=IDLE, fetch_addr=0, instr=0, instr_valid=0, pc=0, halted=0. Memory contents are not cleared.
- States: IDLE, FETCH, PRESENT, HALTED.
- IDLE: run=1 -> FETCH with fetch_addr=0. All other inputs except load are ignored.
- FETCH: synchronous memory read of fetch_addr. On the next edge -> PRESENT: instr=mem[fetch_addr], pc=fetch_addr, instr_valid=1, fetch_addr=fetch_addr+1 modulo 2^AWIDTH (31 wraps to 0).
- PRESENT:
  - instr and pc hold stable while instr_valid && !instr_ready.
  - On handshake: if opcode==OP_HALT -> HALTED with instr_valid=0 and halted=1; otherwise -> FETCH with instr_valid=0.
  - Base throughput is one instruction per 2 cycles. First instr_valid rises 2 cycles after the run pulse.
- HALTED: halted=1 and instr_valid=0. run=1 -> FETCH at address 0 and clears halted.
- Redirect (FETCH or PRESENT), highest priority:
  - Next edge: instr_valid=0, in-flight read discarded, fetch_addr=redirect_addr, state=FETCH.
  - Handshake in the same cycle as redirect: the instruction counts as consumed, and the redirect target wins.
  - A non-accepted instruction is dropped and not re-presented.
  - Redirect is ignored in IDLE and HALTED.
- Load: load_we writes mem[load_addr]=load_data only in IDLE or HALTED; ignored in FETCH/PRESENT. A write and a run in the same cycle: the write completes and the fetch reads the new data.
- Reset asserted mid-operation: next edge is the reset state; any presented instruction is discarded.

Optional Feature:
IFETCH_PREFETCH_EN
- Defined:
  - While in PRESENT, a read of fetch_addr is issued into a 1-entry prefetch register.
  - On handshake, the prefetched word is presented on the next cycle, giving 1 instruction/cycle with instr_ready held high.
  - HALT stops prefetch use, and redirect flushes the register.
  - First-instruction latency stays 2 cycles.
- Undefined: 2 cycles per instruction as above, with no prefetch register.

Decomposition:
- Shared package cpu_pkg holds:
  - OPCODE_W=5, OPERAND_W=11.
  - Opcode constants OP_PUSH_I=1, OP_ADD=4, OP_CALL=20, OP_RET=21, OP_HALT=31.
  - The fetch state enum.
- One sub-module, instr_mem: single-port memory with synchronous read and write, no reset.

Test Plan:
1. Load mem[0..3]=0x0805, 0x0802, 0x2000, 0xF800; pulse run; instr_ready=1 -> instructions presented in order at pc 0,1,2,3; first instr_valid 2 cycles after run; halted=1 after 0xF800 is accepted; instr_valid stays 0.
2. Backpressure: after test 1's run, hold instr_ready=0 for 5 cycles -> instr=0x0805 and pc=0 stable and instr_valid=1 throughout; sequence resumes unchanged on ready.
3. Redirect: mem[5]=0xA004; assert redirect_valid with redirect_addr=5 while pc=1 is presented and not accepted -> next valid instr=0xA004 at pc=5; 0x0802 is never accepted.
4. Wrap: mem[31]=0x0800, mem[0]=0x0805; redirect to 31 -> pc 31 (0x0800), then pc 0 (0x0805).
5. Reset mid-run: assert reset while instr_valid=1 -> next cycle instr_valid=0 and state IDLE; load_we during the run was ignored (mem[2] still 0x2000); run again -> 0x0805 at pc 0.
6. With IFETCH_PREFETCH_EN and instr_ready=1 -> test-1 program delivers instructions on 4 consecutive cycles.
